// File: rtl/adcinterface_rx.sv
// Serial ADC reader: periodically pulses conv, clocks 16 bits out of the ADC MSB-first
// on a divided sclk, and presents each result as a parallel word with a valid strobe.
//
// state   | meaning
// IDLE    | waiting for the period counter to expire with en high
// CONVERT | conv high, ADC converting
// SHIFT   | sclk running, sdo shifted in on each sclk rise
// DONE    | publish sample and pulse sample_valid
module adcinterface_rx #(
  parameter int CLK_DIV       = 4,
  parameter int CONV_CYCLES   = 200,
  parameter int SAMPLE_PERIOD = 2500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        sdo,
  output logic        sclk,
  output logic        conv,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        busy
);

  localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONVERT, SHIFT, DONE} state_t;

  state_t          state;
  logic [PW-1:0]   period_cnt;
  logic [CW-1:0]   conv_cnt;
  logic [DW-1:0]   div_cnt;
  logic [3:0]      bit_cnt;
  logic [15:0]     shreg;
  logic            period_zero;
  logic            frame_start;

  assign period_zero = (period_cnt == '0);
  assign frame_start = en && period_zero && (state == IDLE);

  // Expiry outside IDLE still reloads, so an in-progress frame is never restarted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
    end else if (en) begin
      if (period_zero) period_cnt <= PW'(SAMPLE_PERIOD - 1);
      else             period_cnt <= period_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      conv_cnt     <= '0;
      div_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      sclk         <= 1'b0;
      conv         <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          sclk <= 1'b0;
          if (frame_start) begin
            state    <= CONVERT;
            conv     <= 1'b1;
            busy     <= 1'b1;
            conv_cnt <= CW'(CONV_CYCLES - 1);
          end
        end
        CONVERT: begin
          if (conv_cnt == '0) begin
            state   <= SHIFT;
            conv    <= 1'b0;
            div_cnt <= DW'(CLK_DIV - 1);
            bit_cnt <= '0;
          end else begin
            conv_cnt <= conv_cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt == '0) begin
            div_cnt <= DW'(CLK_DIV - 1);
            sclk    <= ~sclk;
            // sdo is launched by the ADC off our own sclk fall, so it is stable at the rise
            if (!sclk) begin
              shreg <= {shreg[14:0], sdo};
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd15) state <= DONE;
            end
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        DONE: begin
          sample       <= shreg;
          sample_valid <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adcinterface_rx.sv
// Bench for adcinterface_rx: ADC model on sdo, scoreboard of expected samples,
// and a protocol monitor sampling on the falling clock edge.
module tb_adcinterface_rx;
  localparam int D = 2;
  localparam int C = 4;
  localparam int P = 80;
  localparam int LAT = C + 32 * D + 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        sdo = 1'b0;
  logic        sclk;
  logic        conv;
  logic [15:0] sample;
  logic        sample_valid;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] adc_q[$];
  logic [15:0] exp_q[$];
  int          valid_times[$];

  adcinterface_rx #(.CLK_DIV(D), .CONV_CYCLES(C), .SAMPLE_PERIOD(P)) dut (
    .clk(clk), .reset(reset), .en(en), .sdo(sdo), .sclk(sclk), .conv(conv),
    .sample(sample), .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ADC model: MSB presented at conversion start, next bit after every sclk fall
  logic [15:0] adc_word = '0;
  logic        a_conv_p = 1'b0;
  logic        a_sclk_p = 1'b0;
  always @(negedge clk) begin
    if (conv && !a_conv_p) begin
      adc_word = (adc_q.size() > 0) ? adc_q.pop_front() : 16'h0000;
      sdo = adc_word[15];
      adc_word = adc_word << 1;
    end else if (!sclk && a_sclk_p) begin
      sdo = adc_word[15];
      adc_word = adc_word << 1;
    end
    a_conv_p = conv;
    a_sclk_p = sclk;
  end

  // Protocol monitor and scoreboard
  int          cyc = 0;
  int          start_cyc = 0;
  int          rises = 0;
  int          conv_rises = 0;
  int          n_valid = 0;
  int          conv_len = 0;
  int          hi_len = 0;
  logic        busy_m = 1'b0;
  logic        sclk_p = 1'b0;
  logic        conv_p = 1'b0;
  logic        valid_p = 1'b0;
  logic [15:0] sample_p = '0;
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      busy_m = 1'b0; rises = 0; sclk_p = 1'b0; conv_p = 1'b0; valid_p = 1'b0;
      sample_p = sample;
    end else begin
      if (valid_p) busy_m = 1'b0;
      if (conv && !conv_p) begin
        busy_m = 1'b1; conv_rises++; start_cyc = cyc; rises = 0; conv_len = 0;
      end
      if (conv) conv_len++;
      if (!conv && conv_p) check("conv_len", conv_len, C);
      check("busy", busy, busy_m);
      check("sclk_edge_in_conv", conv && (sclk !== sclk_p), 0);
      check("sclk_idle_low", !busy && sclk, 0);
      if (sclk && !sclk_p) begin rises++; hi_len = 0; end
      if (sclk) hi_len++;
      if (!sclk && sclk_p) check("sclk_high_len", hi_len, D);
      if (sample_valid) begin
        check("valid_width", valid_p, 0);
        check("sclk_rises", rises, 16);
        check("latency", cyc - start_cyc, LAT);
        if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
        else check("sample", sample, exp_q.pop_front());
        valid_times.push_back(cyc);
        n_valid++;
      end else begin
        check("sample_stable", sample, sample_p);
      end
      sclk_p = sclk; conv_p = conv; valid_p = sample_valid; sample_p = sample;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int n, input int budget);
    int target;
    target = n_valid + n;
    for (int i = 0; i < budget && n_valid < target; i++) @(posedge clk);
    #2;
    check("valid_timeout", n_valid >= target, 1);
  endtask

  task automatic wait_rises(input int cr, input int r, input int budget);
    for (int i = 0; i < budget && !(conv_rises > cr && rises >= r); i++) @(posedge clk);
    #2;
    check("rise_timeout", (conv_rises > cr) && (rises >= r), 1);
  endtask

  task automatic push_word(input logic [15:0] w);
    adc_q.push_back(w);
    exp_q.push_back(w);
  endtask

  initial begin
    int cr;
    int nt;
    reset = 1'b1;
    en = 1'b0;
    step(3);
    check("rst_sclk", sclk, 0);
    check("rst_conv", conv, 0);
    check("rst_sample", sample, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    step(3);
    check("idle_no_conv", conv, 0);

    // single frame
    push_word(16'hA5C3);
    en = 1'b1;
    step(1);
    check("conv_first_edge", conv, 1);
    wait_valid(1, 200);
    en = 1'b0;

    // periodic capture
    step(20);
    push_word(16'h0000);
    push_word(16'hFFFF);
    push_word(16'h8001);
    en = 1'b1;
    wait_valid(3, 400);
    nt = valid_times.size();
    check("period_1", valid_times[nt-2] - valid_times[nt-3], P);
    check("period_2", valid_times[nt-1] - valid_times[nt-2], P);

    // enable drop during SHIFT
    push_word(16'h5A0F);
    cr = conv_rises;
    wait_rises(cr, 3, 200);
    en = 1'b0;
    wait_valid(1, 200);
    cr = conv_rises;
    step(500);
    check("no_conv_after_drop", conv_rises - cr, 0);

    // reset during SHIFT
    push_word(16'hDEAD);
    en = 1'b1;
    cr = conv_rises;
    wait_rises(cr, 7, 400);
    reset = 1'b1;
    #1;
    check("midrst_sclk", sclk, 0);
    check("midrst_conv", conv, 0);
    check("midrst_sample", sample, 0);
    check("midrst_valid", sample_valid, 0);
    check("midrst_busy", busy, 0);
    adc_q.delete();
    exp_q.delete();
    step(3);
    push_word(16'h1234);
    reset = 1'b0;
    wait_valid(1, 200);
    en = 1'b0;
    step(5);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
